// File: rtl/ctrl_encoder.sv
// Re-encodes decoded control bundles into 4-bit opcodes and packs them into trace words.
// Illegal bundles are dropped and counted.
module ctrl_encoder #(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned ERR_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 func_ctrl,
  input  logic [11:0]                ctl,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*NIBBLES-1:0]       out_word,
  output logic [$clog2(NIBBLES):0]   out_cnt,
  output logic                       err,
  output logic [ERR_W-1:0]           err_count
);

  localparam int unsigned CW = $clog2(NIBBLES) + 1;
  localparam int unsigned WW = 4 * NIBBLES;
  localparam logic [CW-1:0] FullCnt = CW'(NIBBLES);

  logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
  logic [WW-1:0]    acc_data_q, acc_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WW-1:0]    out_word_q, out_word_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             accept, legal, wr, out_free, flush_go, load;
  logic [3:0]       opcode;
  logic [CW-1:0]    cnt_after;
  logic [WW-1:0]    data_after;

  // Exact-match decode: control bits and func_ctrl must both match one opcode.
  always_comb begin
    legal  = 1'b1;
    opcode = 4'h0;
    case ({ctl, func_ctrl})
      {12'hE40, 8'h40}: opcode = 4'b0000;
      {12'h050, 8'h40}: opcode = 4'b0001;
      {12'h080, 8'h40}: opcode = 4'b0010;
      {12'h120, 8'h04}: opcode = 4'b0100;
      {12'h24D, 8'h40}: opcode = 4'b1000;
      {12'h263, 8'h02}: opcode = 4'b1100;
      {12'h263, 8'h04}: opcode = 4'b1101;
      {12'h263, 8'h08}: opcode = 4'b1110;
      {12'h263, 8'h10}: opcode = 4'b1111;
      default:          legal  = 1'b0;
    endcase
  end

  assign in_ready = ~(out_valid_q & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign wr       = accept & legal;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    cnt_after  = acc_cnt_q + CW'(wr);
    data_after = acc_data_q;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (wr && acc_cnt_q == CW'(i)) data_after[4*i +: 4] = opcode;
    end
  end

  // A completing nibble can only be accepted when the output is free or draining.
  assign flush_go = flush & (cnt_after != '0) & out_free;
  assign load     = (cnt_after == FullCnt) | flush_go;

  always_comb begin
    acc_cnt_d   = cnt_after;
    acc_data_d  = data_after;
    out_valid_d = out_valid_q & ~out_ready;
    out_word_d  = out_word_q;
    out_cnt_d   = out_cnt_q;
    err_d       = accept & ~legal;
    err_count_d = err_count_q;
    if (load) begin
      acc_cnt_d   = '0;
      acc_data_d  = '0;
      out_valid_d = 1'b1;
      out_word_d  = data_after;
      out_cnt_d   = cnt_after;
    end
    if (err_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= '0;
      acc_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      acc_data_q  <= acc_data_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_cnt   = out_cnt_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_ctrl_encoder.sv
// Randomised bench for ctrl_encoder against a queue-based reference model,
// with directed sequences pinned by literal expectations.
module tb_ctrl_encoder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, err;
  logic [7:0]  func_ctrl;
  logic [11:0] ctl;
  logic [15:0] out_word;
  logic [2:0]  out_cnt;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  ctrl_encoder #(.NIBBLES(N), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func_ctrl(func_ctrl), .ctl(ctl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_cnt(out_cnt), .err(err),
    .err_count(err_count)
  );

  typedef struct {
    logic [11:0] c;
    logic [7:0]  f;
    logic [3:0]  op;
  } enc_t;
  enc_t tbl[9];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_known = 0;
  bit          m_ov;
  logic [15:0] m_word;
  int          m_cnt;
  bit          m_err;
  int          m_errc;
  logic [3:0]  q[$];

  function automatic bit lookup(input logic [11:0] c, input logic [7:0] f,
                                output logic [3:0] op);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].c == c && tbl[i].f == f) begin
        op = tbl[i].op;
        return 1'b1;
      end
    end
    op = 4'h0;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] op;
    bit rdy;
    if (rst) begin
      m_known = 1; m_ov = 0; m_word = 0; m_cnt = 0; m_err = 0; m_errc = 0;
      q.delete();
      return;
    end
    if (!m_known) return;
    rdy   = !(m_ov && !out_ready);
    m_err = 0;
    if (in_valid && rdy) begin
      if (lookup(ctl, func_ctrl, op)) q.push_back(op);
      else begin
        m_err = 1;
        if (m_errc < 255) m_errc++;
      end
    end
    if (m_ov && out_ready) m_ov = 0;
    if (q.size() == N || (flush && q.size() > 0 && !m_ov)) begin
      m_word = 0;
      foreach (q[i]) m_word = m_word | (16'(q[i]) << (4 * i));
      m_cnt = q.size();
      m_ov  = 1;
      q.delete();
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the DUT samples next.
  task automatic cycle();
    @(negedge clk);
    if (m_known) begin
      check("in_ready", in_ready, !(m_ov && !out_ready));
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_word", out_word, m_word);
        check("out_cnt", out_cnt, m_cnt);
      end
      check("err", err, m_err);
      check("err_count", err_count, m_errc);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [11:0] c, input logic [7:0] f,
                       input bit fl, input bit ordy);
    in_valid = v; ctl = c; func_ctrl = f; flush = fl; out_ready = ordy;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 12'h0, 8'h0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] c;
    logic [7:0]  f;
    int          k;
    tbl[0] = '{12'hE40, 8'h40, 4'h0};
    tbl[1] = '{12'h050, 8'h40, 4'h1};
    tbl[2] = '{12'h080, 8'h40, 4'h2};
    tbl[3] = '{12'h120, 8'h04, 4'h4};
    tbl[4] = '{12'h24D, 8'h40, 4'h8};
    tbl[5] = '{12'h263, 8'h02, 4'hC};
    tbl[6] = '{12'h263, 8'h04, 4'hD};
    tbl[7] = '{12'h263, 8'h08, 4'hE};
    tbl[8] = '{12'h263, 8'h10, 4'hF};
    rst = 1'b0; in_valid = 0; ctl = 0; func_ctrl = 0; flush = 0; out_ready = 0;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);

    // LOAD, STORE, JUMP, BRANCHZ
    drive(1, 12'hE40, 8'h40, 0, 1);
    drive(1, 12'h050, 8'h40, 0, 1);
    drive(1, 12'h080, 8'h40, 0, 1);
    drive(1, 12'h120, 8'h04, 0, 1);
    check("w1_valid", out_valid, 1);
    check("w1_word", out_word, 16'h4210);
    check("w1_cnt", out_cnt, 4);
    check("w1_errc", err_count, 0);

    // I-type set, then TYPEC with flush
    drive(1, 12'h263, 8'h02, 0, 1);
    drive(1, 12'h263, 8'h04, 0, 1);
    drive(1, 12'h263, 8'h08, 0, 1);
    drive(1, 12'h263, 8'h10, 0, 1);
    check("w2_word", out_word, 16'hFEDC);
    check("w2_cnt", out_cnt, 4);
    drive(1, 12'h24D, 8'h40, 1, 1);
    check("w3_word", out_word, 16'h0008);
    check("w3_cnt", out_cnt, 1);
    drive(0, 12'h0, 8'h0, 0, 1);

    // Backpressure
    repeat (4) drive(1, 12'h080, 8'h40, 0, 0);
    repeat (3) drive(1, 12'hE40, 8'h40, 0, 0);
    check("stall_in_ready", in_ready, 0);
    check("stall_word", out_word, 16'h2222);
    drive(1, 12'hE40, 8'h40, 0, 1);
    drive(0, 12'h0, 8'h0, 1, 0);
    check("after_stall_valid", out_valid, 1);
    check("after_stall_word", out_word, 16'h0000);
    check("after_stall_cnt", out_cnt, 1);

    // Reset discards a pending word, then a partial accumulator
    do_reset();
    check("rst_pend_valid", out_valid, 0);
    drive(1, 12'h050, 8'h40, 0, 1);
    drive(1, 12'h050, 8'h40, 0, 1);
    do_reset();
    check("rst_part_valid", out_valid, 0);
    check("rst_part_errc", err_count, 0);
    repeat (4) drive(1, 12'h080, 8'h40, 0, 1);
    check("rst_part_word", out_word, 16'h2222);
    check("rst_part_cnt", out_cnt, 4);
    drive(0, 12'h0, 8'h0, 0, 1);

    // Illegal bundles
    do_reset();
    drive(1, 12'h000, 8'h40, 0, 1);
    drive(1, 12'h120, 8'h02, 0, 1);
    drive(1, 12'hE42, 8'h40, 0, 1);
    check("ill_err", err, 1);
    check("ill_errc", err_count, 3);
    check("ill_valid", out_valid, 0);
    drive(0, 12'h0, 8'h0, 1, 1);
    check("ill_flush_valid", out_valid, 0);
    check("ill_err_clear", err, 0);

    // Saturation
    for (int i = 0; i < 260; i++) drive(1, 12'h000, 8'h40, 0, 1);
    check("sat_errc", err_count, 255);
    check("sat_err", err, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        k = $urandom_range(0, 8);
        c = tbl[k].c;
        f = tbl[k].f;
        if ($urandom_range(0, 9) == 0) c[$urandom_range(0, 11)] ^= 1'b1;
      end else begin
        c = 12'($urandom);
        f = 8'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, c, f, $urandom_range(0, 6) == 0,
            $urandom_range(0, 9) < 7);
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
